rx_gearbox_32b_66b: RTL and testbench

- RX-side gearbox: converts a continuous 32-bit/cycle serial-ordered word stream into 64b/66b blocks.
- Each block is presented as a 2-bit header plus two consecutive 32-bit payload words.
- Sits between the transceiver RX datapath (no internal gearbox) and the block-lock/descrambler logic.
- slip_i lets the lock logic shift block alignment by one bit per pulse.

---
 rtl/rx_gearbox_32b_66b.sv | 99 +++++++++
 tb/tb_rx_gearbox_32b_66b.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_gearbox_32b_66b.sv
// rx_gearbox_32b_66b
// RX gearbox: 32-bit/cycle bit stream in, 64b/66b blocks out as
// header + two 32-bit payload words. slip_i drops one bit per accepted
// pulse to move the block alignment during lock hunting.
// Optional: define RX_GEARBOX_DATA_VALID_EN to add a registered
// data_valid_o output that marks every cycle carrying a new word.
module rx_gearbox_32b_66b #(
  parameter int SLIP_IGNORE_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic        slip_i,
  output logic [31:0] data_o,
  output logic [1:0]  head_o,
  output logic        head_valid_o
`ifdef RX_GEARBOX_DATA_VALID_EN
  ,
  output logic        data_valid_o
`endif
);

  localparam int CW = (SLIP_IGNORE_CYCLES > 0) ? $clog2(SLIP_IGNORE_CYCLES + 1) : 1;

  logic [95:0]   r_buf;
  logic [5:0]    r_fill;
  logic          r_phase_d;
  logic [CW-1:0] r_ign;

  logic          w_slip_acc;
  logic [95:0]   w_cat;
  logic [95:0]   w_al;
  logic [6:0]    w_avail;
  logic          w_take_h;
  logic          w_take_d;

  // Merge the new word above the held bits, then apply an accepted slip by
  // dropping the oldest bit; this covers the fill=0 case (drop data_i[0]).
  always_comb begin
    w_slip_acc = slip_i && (r_ign == '0);
    w_cat      = r_buf | ({64'd0, data_i} << r_fill);
    w_al       = w_slip_acc ? (w_cat >> 1) : w_cat;
    w_avail    = {1'b0, r_fill} + 7'd32 - {6'd0, w_slip_acc};
    w_take_h   = !r_phase_d && (w_avail >= 7'd34);
    w_take_d   = r_phase_d && (w_avail >= 7'd32);
  end

  // Slip ignore window: loads on each accepted slip, counts down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ign <= '0;
    end else if (w_slip_acc) begin
      r_ign <= CW'(SLIP_IGNORE_CYCLES);
    end else if (r_ign != '0) begin
      r_ign <= r_ign - CW'(1);
    end
  end

  // Consume a header+word, a second word, or stall; outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf        <= '0;
      r_fill       <= '0;
      r_phase_d    <= 1'b0;
      data_o       <= '0;
      head_o       <= '0;
      head_valid_o <= 1'b0;
    end else if (w_take_h) begin
      head_o       <= w_al[1:0];
      data_o       <= w_al[33:2];
      head_valid_o <= 1'b1;
      r_buf        <= w_al >> 34;
      r_fill       <= 6'(w_avail - 7'd34);
      r_phase_d    <= 1'b1;
    end else if (w_take_d) begin
      data_o       <= w_al[31:0];
      head_valid_o <= 1'b0;
      r_buf        <= w_al >> 32;
      r_fill       <= 6'(w_avail - 7'd32);
      r_phase_d    <= 1'b0;
    end else begin
      head_valid_o <= 1'b0;
      r_buf        <= w_al;
      r_fill       <= 6'(w_avail);
    end
  end

`ifdef RX_GEARBOX_DATA_VALID_EN
  // Word strobe: high for any cycle that produced a new data_o word.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid_o <= 1'b0;
    end else begin
      data_valid_o <= w_take_h || w_take_d;
    end
  end
`endif

endmodule

// File: tb/tb_rx_gearbox_32b_66b.sv
// Scoreboard bench for rx_gearbox_32b_66b: bit-queue reference model,
// two DUTs (slip ignore window 0 and 32) fed the same data stream.
module tb_rx_gearbox_32b_66b;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] data_i = '0;
  logic        slip0 = 1'b0, slip1 = 1'b0;
  logic [31:0] do0, do1;
  logic [1:0]  ho0, ho1;
  logic        hv0, hv1;
`ifdef RX_GEARBOX_DATA_VALID_EN
  logic        dv0, dv1;
`endif

  rx_gearbox_32b_66b #(.SLIP_IGNORE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .data_i(data_i), .slip_i(slip0),
    .data_o(do0), .head_o(ho0), .head_valid_o(hv0)
`ifdef RX_GEARBOX_DATA_VALID_EN
    , .data_valid_o(dv0)
`endif
  );

  rx_gearbox_32b_66b #(.SLIP_IGNORE_CYCLES(32)) dut1 (
    .clk(clk), .rst(rst), .data_i(data_i), .slip_i(slip1),
    .data_o(do1), .head_o(ho1), .head_valid_o(hv1)
`ifdef RX_GEARBOX_DATA_VALID_EN
    , .data_valid_o(dv1)
`endif
  );

  typedef struct {
    logic        hv;
    logic        dv;
    logic        rs;
    logic [1:0]  head;
    logic [31:0] data;
    int          tag;
    bit          al;
  } exp_t;

  exp_t eq0[$];
  exp_t eq1[$];
  bit   mq0[$];
  bit   mq1[$];
  bit   mph[2];
  int   mign[2];
  logic [31:0] mlast[2];

  int checks = 0;
  int failures = 0;

  logic        hv_log[101];
  logic [1:0]  head_log[101];
  logic [31:0] data_log[101];

  bit src[$];
  bit rnd_mode;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: bits in a queue, oldest first; blocks taken in H/D order.
  task automatic model_step(input int u, input logic [31:0] d, input logic s,
                            input logic r, input int tag, input bit al);
    bit q[$];
    exp_t e;
    int win;
    win = (u == 0) ? 0 : 32;
    if (u == 0) q = mq0; else q = mq1;
    e.hv = 0; e.dv = 0; e.rs = r; e.head = 2'b00; e.tag = tag; e.al = al;
    if (r) begin
      q.delete();
      mph[u] = 0; mign[u] = 0; mlast[u] = '0;
    end else begin
      for (int i = 0; i < 32; i++) q.push_back(d[i]);
      if (s && mign[u] == 0) begin
        void'(q.pop_front());
        mign[u] = win;
      end else if (mign[u] > 0) begin
        mign[u]--;
      end
      if (!mph[u] && q.size() >= 34) begin
        e.head = {q[1], q[0]};
        for (int i = 0; i < 32; i++) mlast[u][i] = q[i+2];
        repeat (34) void'(q.pop_front());
        e.hv = 1; e.dv = 1; mph[u] = 1;
      end else if (mph[u] && q.size() >= 32) begin
        for (int i = 0; i < 32; i++) mlast[u][i] = q[i];
        repeat (32) void'(q.pop_front());
        e.dv = 1; mph[u] = 0;
      end
    end
    e.data = mlast[u];
    if (u == 0) begin mq0 = q; eq0.push_back(e); end
    else        begin mq1 = q; eq1.push_back(e); end
  endtask

  task automatic check_out(input int u);
    exp_t e;
    logic hv, dv;
    logic [1:0] h;
    logic [31:0] d;
    bit good;
    dv = 1'b0;
    if (u == 0) begin
      if (eq0.size() == 0) return;
      e = eq0.pop_front(); hv = hv0; h = ho0; d = do0;
`ifdef RX_GEARBOX_DATA_VALID_EN
      dv = dv0;
`endif
    end else begin
      if (eq1.size() == 0) return;
      e = eq1.pop_front(); hv = hv1; h = ho1; d = do1;
`ifdef RX_GEARBOX_DATA_VALID_EN
      dv = dv1;
`endif
    end
    good = (hv === e.hv) && (d === e.data) && (!(e.hv || e.rs) || h === e.head);
`ifdef RX_GEARBOX_DATA_VALID_EN
    good = good && (dv === e.dv);
`endif
    checks++;
    if (!good) begin
      failures++;
      $display("FAIL sb_dut%0d t=%0t actual hv=%b head=%b data=%h dv=%b required hv=%b head=%b data=%h dv=%b",
               u, $time, hv, h, d, dv, e.hv, e.head, e.data, e.dv);
    end
    if (u == 0 && e.tag > 0 && e.tag <= 100) begin
      hv_log[e.tag] = hv; head_log[e.tag] = h; data_log[e.tag] = d;
    end
    if (u == 0 && e.al && hv === 1'b1) begin
      checks++;
      if (h !== 2'b01 && h !== 2'b10) begin
        failures++;
        $display("FAIL aligned_header actual=%b required=01/10", h);
      end
    end
  endtask

  // Monitor: one result per cycle, sampled 2 time units after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      check_out(0);
      check_out(1);
    end
  end

  task automatic push_block();
    logic [1:0]  h;
    logic [63:0] p;
    if (rnd_mode) begin
      h = ($urandom % 2 == 0) ? 2'b01 : 2'b10;
      p = {$urandom, $urandom};
    end else begin
      h = 2'b01;
      p = 64'h0123456789ABCDEF;
    end
    for (int i = 0; i < 2; i++) src.push_back(h[i]);
    for (int i = 0; i < 64; i++) src.push_back(p[i]);
  endtask

  task automatic get_word(output logic [31:0] w);
    while (src.size() < 32) push_block();
    for (int i = 0; i < 32; i++) w[i] = src.pop_front();
  endtask

  task automatic cycle(input logic [31:0] d, input logic s0, input logic s1,
                       input logic r, input int tag, input bit al);
    @(negedge clk);
    rst = r; data_i = d; slip0 = s0; slip1 = s1;
    model_step(0, d, s0, r, tag, al);
    model_step(1, d, s1, r, 0, 0);
  endtask

  initial begin
    logic [31:0] w;
    int cnt, g3, gbad, last;
    rnd_mode = 0;
    repeat (3) cycle('0, 0, 0, 1, 0, 0);

    for (int c = 1; c <= 100; c++) begin
      get_word(w);
      cycle(w, 0, 0, 0, c, 0);
    end

    // Single-cycle reset mid-block, then keep streaming unaligned words.
    cycle('0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 70; c++) begin
      get_word(w);
      cycle(w, 0, 0, 0, 0, 0);
    end

    // Random blocks preceded by 5 junk bits; DUT0 slips every 40 cycles,
    // DUT1 sees slip held for 10 cycles inside its ignore window.
    cycle('0, 0, 0, 1, 0, 0);
    src.delete();
    rnd_mode = 1;
    for (int i = 0; i < 5; i++) src.push_back(1'($urandom % 2));
    for (int c = 0; c < 260; c++) begin
      get_word(w);
      cycle(w, (c % 40 == 20) && (c <= 180), (c >= 20) && (c < 30), 0, 0, c >= 190);
    end

    for (int c = 0; c < 500; c++) begin
      w = $urandom;
      cycle(w, $urandom % 7 == 0, $urandom % 5 == 0, c == 250, 0, 0);
    end

    repeat (3) @(negedge clk);
    chk("queue0_drained", 64'(eq0.size()), 64'd0);
    chk("queue1_drained", 64'(eq1.size()), 64'd0);

    chk("first_out_stall", 64'(hv_log[1]), 64'd0);
    chk("first_head_valid", 64'(hv_log[2]), 64'd1);
    chk("first_head", 64'(head_log[2]), 64'h1);
    chk("first_word", 64'(data_log[2]), 64'h89ABCDEF);
    chk("second_word", 64'(data_log[3]), 64'h01234567);
    chk("second_word_hv", 64'(hv_log[3]), 64'd0);

    cnt = 0; g3 = 0; gbad = 0; last = 0;
    for (int k = 1; k <= 99; k++) begin
      if (hv_log[k] === 1'b1) begin
        cnt++;
        if (head_log[k] !== 2'b01) gbad++;
        if (last != 0) begin
          if (k - last == 3) g3++;
          else if (k - last != 2) gbad++;
        end
        last = k;
      end
    end
    chk("blocks_in_99", 64'(cnt), 64'd48);
    chk("three_cycle_gaps", 64'(g3), 64'd2);
    chk("bad_gap_or_head", 64'(gbad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
